// File: rtl/pipe_sub_pkg.sv
// Shared types and defaults for the pipelined subtractor / countdown block.
package pipe_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cd_state_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_FAST_STEP = 3;

endpackage

// File: rtl/sub_pipe_stage.sv
// One valid/ready register slice. The slice accepts new data when it is empty
// or when its current content is leaving this cycle.
module sub_pipe_stage #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_sub_countdown.sv
// Two-stage pipelined subtractor with valid/ready handshake, plus an
// independent saturating down-counter with a terminal-count FSM.
//
//   state | meaning
//   IDLE  | counter holds, waiting for load
//   RUN   | counting down by 1 (or FAST_STEP when ena)
//   DONE  | single cycle at terminal count, done = 1
module pipe_sub_countdown
    import pipe_sub_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FAST_STEP = DEFAULT_FAST_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             borrow,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ena,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] STEP_FAST = WIDTH'(FAST_STEP);
    localparam logic [WIDTH-1:0] STEP_ONE  = WIDTH'(1);

    // Subtractor pipeline; the extra MSB of the difference is the borrow.
    logic [WIDTH:0] diff;
    logic [WIDTH:0] s1_data;
    logic [WIDTH:0] s2_data;
    logic           s1_valid;
    logic           s2_ready;

    assign diff = {1'b0, A} - {1'b0, B};

    sub_pipe_stage #(.W(WIDTH + 1)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (diff),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    sub_pipe_stage #(.W(WIDTH + 1)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign borrow = s2_data[WIDTH];
    assign dout   = s2_data[WIDTH-1:0];

    // Countdown FSM
    cd_state_t        state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] step;

    assign step = ena ? STEP_FAST : STEP_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (load) begin
            cnt_nxt   = load_val;
            state_nxt = (load_val == '0) ? DONE : RUN;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                RUN: begin
                    // Saturate at zero rather than wrapping on a large step.
                    if (cnt <= step) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - step;
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pipe_sub_countdown.sv
// Directed bench for pipe_sub_countdown: subtractor pipeline, backpressure,
// countdown modes, reload and asynchronous reset.
module tb_pipe_sub_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;
    logic       borrow;
    logic       load;
    logic [7:0] load_val;
    logic       ena;
    logic [7:0] cnt;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    pipe_sub_countdown #(.WIDTH(8), .FAST_STEP(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .borrow    (borrow),
        .load      (load),
        .load_val  (load_val),
        .ena       (ena),
        .cnt       (cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b0;
        load = 1'b0; load_val = '0; ena = 1'b0;
        #3;
        n_cmp++;
        if ({out_valid, dout, borrow, cnt, busy, done} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got ov=%b dout=%0d br=%b cnt=%0d busy=%b done=%b, want all 0",
                     out_valid, dout, borrow, cnt, busy, done);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL post_reset: got in_ready=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_pipe_borrow();
        out_ready = 1'b1;
        in_valid = 1'b1; A = 8'd200; B = 8'd55;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL pipe_accept: got in_ready=%b want 1", in_ready);
        end
        step();
        A = 8'd10; B = 8'd20;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || dout !== 8'd145 || borrow !== 1'b0) begin
            n_err++; $display("FAIL pipe_first: got ov=%b dout=%0d br=%b want 1 145 0", out_valid, dout, borrow);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || dout !== 8'd246 || borrow !== 1'b1) begin
            n_err++; $display("FAIL pipe_second: got ov=%b dout=%0d br=%b want 1 246 1", out_valid, dout, borrow);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL pipe_drain: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] va [4] = '{8'd50, 8'd7,  8'd255, 8'd100};
        logic [7:0] vb [4] = '{8'd20, 8'd9,  8'd0,   8'd100};
        logic [8:0] ve [4] = '{9'd30, 9'h1FE, 9'd255, 9'd0};
        int  idx = 0;
        int  rcv = 0;
        bit  stalled = 0;
        bit  saw_not_ready = 0;
        logic [8:0] held = '0;
        for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
            in_valid  = (idx < 4);
            A         = (idx < 4) ? va[idx] : 8'd0;
            B         = (idx < 4) ? vb[idx] : 8'd0;
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {borrow, dout} !== held) begin
                    n_err++; $display("FAIL bp_stable: got ov=%b {br,dout}=%h want 1 %h", out_valid, {borrow, dout}, held);
                end
            end
            if (cyc == 2) saw_not_ready = (in_ready == 1'b0);
            stalled = out_valid && !out_ready;
            held    = {borrow, dout};
            if (out_valid && out_ready) begin
                n_cmp++;
                if ({borrow, dout} !== ve[rcv]) begin
                    n_err++; $display("FAIL bp_result%0d: got %h want %h", rcv, {borrow, dout}, ve[rcv]);
                end
                rcv++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #0;
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (!saw_not_ready) begin
            n_err++; $display("FAIL bp_in_ready_drop: got in_ready=1 while full, want 0");
        end
        n_cmp++;
        if (rcv !== 4 || idx !== 4) begin
            n_err++; $display("FAIL bp_count: got sent=%0d recv=%0d want 4 4", idx, rcv);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_no_dup: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_countdown();
        int ec [5] = '{3, 2, 1, 0, 0};
        int eb [5] = '{1, 1, 1, 0, 0};
        int ed [5] = '{0, 0, 0, 1, 0};
        load = 1'b1; load_val = 8'd3; ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            load = 1'b0;
            n_cmp++;
            if (cnt !== 8'(ec[i]) || busy !== 1'(eb[i]) || done !== 1'(ed[i])) begin
                n_err++; $display("FAIL count_norm[%0d]: got cnt=%0d busy=%b done=%b want %0d %0d %0d",
                                  i, cnt, busy, done, ec[i], eb[i], ed[i]);
            end
        end
    endtask

    task automatic test_fast_saturate();
        int ec [4] = '{5, 2, 0, 0};
        int eb [4] = '{1, 1, 0, 0};
        int ed [4] = '{0, 0, 1, 0};
        load = 1'b1; load_val = 8'd5; ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            load = 1'b0;
            n_cmp++;
            if (cnt !== 8'(ec[i]) || busy !== 1'(eb[i]) || done !== 1'(ed[i])) begin
                n_err++; $display("FAIL count_fast[%0d]: got cnt=%0d busy=%b done=%b want %0d %0d %0d",
                                  i, cnt, busy, done, ec[i], eb[i], ed[i]);
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_zero_reload();
        load = 1'b1; load_val = 8'd0;
        step();
        load = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || cnt !== 8'd0) begin
            n_err++; $display("FAIL zero_load: got done=%b busy=%b cnt=%0d want 1 0 0", done, busy, cnt);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_idle: got done=%b busy=%b want 0 0", done, busy);
        end
        load = 1'b1; load_val = 8'd4;
        step();
        load = 1'b0;
        step();
        step();
        n_cmp++;
        if (cnt !== 8'd2 || busy !== 1'b1) begin
            n_err++; $display("FAIL reload_pre: got cnt=%0d busy=%b want 2 1", cnt, busy);
        end
        load = 1'b1; load_val = 8'd7;
        step();
        load = 1'b0;
        n_cmp++;
        if (cnt !== 8'd7 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL reload: got cnt=%0d busy=%b done=%b want 7 1 0", cnt, busy, done);
        end
    endtask

    task automatic test_async_reset();
        step();
        n_cmp++;
        if (cnt !== 8'd6 || busy !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_cnt: got cnt=%0d busy=%b want 6 1", cnt, busy);
        end
        in_valid = 1'b1; A = 8'd9; B = 8'd4; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || dout !== 8'd5) begin
            n_err++; $display("FAIL rst_pre_pipe: got ov=%b dout=%0d want 1 5", out_valid, dout);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, dout, borrow, cnt, busy, done} !== 20'd0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_async: got ov=%b dout=%0d br=%b cnt=%0d busy=%b done=%b rdy=%b want 0s, rdy 1",
                              out_valid, dout, borrow, cnt, busy, done, in_ready);
        end
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || cnt !== 8'd0) begin
                n_err++; $display("FAIL rst_after[%0d]: got done=%b ov=%b busy=%b cnt=%0d want 0 0 0 0",
                                  i, done, out_valid, busy, cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_borrow();
        test_backpressure();
        test_countdown();
        test_fast_saturate();
        test_zero_reload();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
